// File: rtl/ate_pkg.sv
// Shared constants and FSM encoding for the adaptive threshold engine sequencer.
package ate_pkg;

   localparam int BLK     = 8;
   localparam int BLK_PIX = 64;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FEED  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_FEED  = ST_FEED,
      S_DRAIN = ST_DRAIN,
      S_DONE  = ST_DONE
   } ate_state_e;

   // The engine has two hard-wired frame geometries; only the 48-wide one uses type 0.
   function automatic logic ate_type_sel(input int img_w);
      return (img_w == 48) ? 1'b0 : 1'b1;
   endfunction

endpackage

// File: rtl/ate_addr_gen.sv
// Block-raster address counter: pixels row-major inside an 8x8 block, blocks
// left-to-right then top-to-bottom, producing the row-major image address.
module ate_addr_gen
   import ate_pkg::*;
#(
   parameter int IMG_W = 48,
   parameter int IMG_H = 32,
   parameter int AW    = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          clr,
   output logic [AW-1:0] addr,
   output logic          blk_first,
   output logic          last
);

   localparam int NBX = IMG_W / BLK;
   localparam int NBY = IMG_H / BLK;
   localparam int BXW = (NBX > 1) ? $clog2(NBX) : 1;
   localparam int BYW = (NBY > 1) ? $clog2(NBY) : 1;

   logic [2:0]     r_px;
   logic [2:0]     r_py;
   logic [BXW-1:0] r_bx;
   logic [BYW-1:0] r_by;
   logic           w_px_max;
   logic           w_py_max;
   logic           w_bx_max;
   logic           w_by_max;

   assign w_px_max = (r_px == 3'd7);
   assign w_py_max = (r_py == 3'd7);
   assign w_bx_max = (r_bx == BXW'(NBX - 1));
   assign w_by_max = (r_by == BYW'(NBY - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_px <= '0;
         r_py <= '0;
         r_bx <= '0;
         r_by <= '0;
      end else if (clr) begin
         r_px <= '0;
         r_py <= '0;
         r_bx <= '0;
         r_by <= '0;
      end else if (en) begin
         r_px <= r_px + 3'd1;
         if (w_px_max) begin
            r_py <= r_py + 3'd1;
            if (w_py_max) begin
               r_bx <= w_bx_max ? '0 : r_bx + BXW'(1);
               if (w_bx_max)
                  r_by <= w_by_max ? '0 : r_by + BYW'(1);
            end
         end
      end
   end

   // {by,py} is bY*8+pY and {bx,px} is bX*8+pX, so only one multiply is needed.
   assign addr      = AW'({r_by, r_py}) * AW'(IMG_W) + AW'({r_bx, r_px});
   assign blk_first = (r_px == 3'd0) && (r_py == 3'd0);
   assign last      = w_px_max && w_py_max && w_bx_max && w_by_max;

endmodule

// File: rtl/ate_stream_ctrl.sv
// Frame sequencer: streams an image into the threshold engine in block order and
// writes back per-pixel bins and per-block thresholds after the engine latency.
module ate_stream_ctrl
   import ate_pkg::*;
#(
   parameter int IMG_W   = 48,
   parameter int IMG_H   = 32,
   parameter int AW      = 12,
   parameter int BIN_LAT = 65,
   parameter int THR_LAT = 65
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] img_addr,
   output logic          img_rd,
   input  logic [7:0]    img_di,
   output logic [7:0]    ate_pix,
   output logic          ate_type,
   input  logic          ate_bin,
   input  logic [7:0]    ate_thr,
   output logic          res_wr,
   output logic [AW-1:0] res_addr,
   output logic          res_bin,
   output logic          thr_wr,
   output logic [AW-1:0] thr_addr,
   output logic [7:0]    thr_val
);

   localparam int LAT_MAX = (BIN_LAT > THR_LAT) ? BIN_LAT : THR_LAT;
   localparam int CW      = $clog2(LAT_MAX + 2) + 1;
   localparam logic [CW-1:0] CYC_SAT = CW'(LAT_MAX + 1);
   localparam logic [CW-1:0] BIN_HIT = CW'(BIN_LAT);
   localparam logic [CW-1:0] THR_HIT = CW'(THR_LAT);

   ate_state_e     r_state;
   logic           r_busy;
   logic           r_done;
   logic           r_img_rd;
   logic           r_rd_d1;
   logic           r_res_act;
   logic           r_thr_act;
   logic           r_res_fin;
   logic           r_thr_fin;
   logic [CW-1:0]  r_cyc;
   logic [AW-1:0]  r_thr_idx;

   logic           w_start_ok;
   logic [AW-1:0]  w_rd_addr;
   logic           w_rd_last;
   logic [AW-1:0]  w_res_addr;
   logic           w_res_last;
   logic           w_thr_first;
   logic           w_thr_last;
   logic           w_res_end;
   logic           w_thr_end;
   logic           w_thr_pulse;
   logic           w_unused_rd_first;
   logic           w_unused_res_first;
   logic [AW-1:0]  w_unused_thr_addr;

   assign w_start_ok = (r_state == S_IDLE) && start;

   ate_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) u_rd_gen (
      .clk       (clk),
      .reset     (reset),
      .en        (r_img_rd),
      .clr       (w_start_ok),
      .addr      (w_rd_addr),
      .blk_first (w_unused_rd_first),
      .last      (w_rd_last)
   );

   ate_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) u_res_gen (
      .clk       (clk),
      .reset     (reset),
      .en        (r_res_act),
      .clr       (w_start_ok),
      .addr      (w_res_addr),
      .blk_first (w_unused_res_first),
      .last      (w_res_last)
   );

   ate_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) u_thr_gen (
      .clk       (clk),
      .reset     (reset),
      .en        (r_thr_act),
      .clr       (w_start_ok),
      .addr      (w_unused_thr_addr),
      .blk_first (w_thr_first),
      .last      (w_thr_last)
   );

   assign w_res_end   = r_res_act && w_res_last;
   assign w_thr_end   = r_thr_act && w_thr_last;
   assign w_thr_pulse = r_thr_act && w_thr_first;

   // r_cyc is 0 in the first read cycle; the write windows open one cycle after it reaches each latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_img_rd  <= 1'b0;
         r_rd_d1   <= 1'b0;
         r_res_act <= 1'b0;
         r_thr_act <= 1'b0;
         r_res_fin <= 1'b0;
         r_thr_fin <= 1'b0;
         r_cyc     <= '0;
         r_thr_idx <= '0;
      end else begin
         r_rd_d1 <= r_img_rd;
         if (r_busy && (r_cyc != CYC_SAT))
            r_cyc <= r_cyc + CW'(1);
         if (r_busy && (r_cyc == BIN_HIT))
            r_res_act <= 1'b1;
         else if (w_res_end)
            r_res_act <= 1'b0;
         if (r_busy && (r_cyc == THR_HIT))
            r_thr_act <= 1'b1;
         else if (w_thr_end)
            r_thr_act <= 1'b0;
         if (w_res_end)
            r_res_fin <= 1'b1;
         if (w_thr_end)
            r_thr_fin <= 1'b1;
         if (w_thr_pulse)
            r_thr_idx <= r_thr_idx + AW'(1);

         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state   <= S_FEED;
                  r_busy    <= 1'b1;
                  r_img_rd  <= 1'b1;
                  r_cyc     <= '0;
                  r_res_fin <= 1'b0;
                  r_thr_fin <= 1'b0;
                  r_thr_idx <= '0;
               end
            end
            S_FEED: begin
               if (w_rd_last) begin
                  r_img_rd <= 1'b0;
                  r_state  <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if ((r_res_fin || w_res_end) && (r_thr_fin || w_thr_end)) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign img_rd   = r_img_rd;
   assign img_addr = w_rd_addr;
   assign ate_pix  = r_rd_d1 ? img_di : 8'd0;
   assign ate_type = ate_type_sel(IMG_W);
   assign res_wr   = r_res_act;
   assign res_addr = w_res_addr;
   assign res_bin  = r_res_act & ate_bin;
   assign thr_wr   = w_thr_pulse;
   assign thr_addr = r_thr_idx;
   assign thr_val  = w_thr_pulse ? ate_thr : 8'd0;

endmodule

// File: tb/tb_ate_stream_ctrl.sv
// Directed bench for ate_stream_ctrl: image RAM and a delay-line engine model,
// stream logging on the falling edge and per-frame checks against a block-order model.
module tb_ate_stream_ctrl;

   localparam int W     = 48;
   localparam int H     = 32;
   localparam int AW    = 12;
   localparam int LAT   = 65;
   localparam int NPIX  = W * H;
   localparam int NBLK  = NPIX / 64;
   localparam int W2    = 528;
   localparam int H2    = 16;
   localparam int AW2   = 14;
   localparam int NPIX2 = W2 * H2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic start2 = 1'b0;

   logic          busy, done, img_rd, ate_type, ate_bin, res_wr, res_bin, thr_wr;
   logic [AW-1:0] img_addr, res_addr, thr_addr;
   logic [7:0]    img_di = 8'd0;
   logic [7:0]    ate_pix, ate_thr, thr_val;

   logic           busy2, done2, img_rd2, ate_type2, res_wr2, res_bin2, thr_wr2;
   logic [AW2-1:0] img_addr2, res_addr2, thr_addr2;
   logic [7:0]     ate_pix2, thr_val2;

   int total = 0;
   int bad   = 0;
   int ncyc  = 0;
   logic [7:0] lvl = 8'd128;
   logic [7:0] mem [0:4095];
   logic [7:0] sr [0:LAT-1] = '{default: 8'd0};

   always #5 clk = ~clk;
   always @(posedge clk) ncyc++;

   ate_stream_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW), .BIN_LAT(LAT), .THR_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .img_addr(img_addr), .img_rd(img_rd), .img_di(img_di), .ate_pix(ate_pix),
      .ate_type(ate_type), .ate_bin(ate_bin), .ate_thr(ate_thr), .res_wr(res_wr),
      .res_addr(res_addr), .res_bin(res_bin), .thr_wr(thr_wr), .thr_addr(thr_addr),
      .thr_val(thr_val)
   );

   ate_stream_ctrl #(.IMG_W(W2), .IMG_H(H2), .AW(AW2), .BIN_LAT(LAT), .THR_LAT(LAT)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
      .img_addr(img_addr2), .img_rd(img_rd2), .img_di(8'd0), .ate_pix(ate_pix2),
      .ate_type(ate_type2), .ate_bin(1'b0), .ate_thr(8'd0), .res_wr(res_wr2),
      .res_addr(res_addr2), .res_bin(res_bin2), .thr_wr(thr_wr2), .thr_addr(thr_addr2),
      .thr_val(thr_val2)
   );

   // Image RAM: data for a read appears in the following cycle.
   always @(posedge clk) if (img_rd) img_di <= mem[img_addr];

   // Engine: bin and threshold both follow the pixel on ate_pix by LAT cycles.
   always @(posedge clk) begin
      sr[0] <= ate_pix;
      for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
   end
   assign ate_bin = (sr[LAT-1] >= lvl);
   assign ate_thr = sr[LAT-1];

   logic log_clr = 1'b0;
   logic mon = 1'b0;
   int   run_s = 0;
   int   rd_n, res_n, thr_n, done_n, done_c, rd_c0, res_c0, res_cl;
   int   busy_gap, pix_err, res_ones, one_addr;
   int   rd_log [NPIX];
   int   res_log [NPIX];
   logic rbin_log [NPIX];
   int   thr_a_log [64];
   int   thr_v_log [64];
   logic prev_rd = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [7:0] ep;

   always @(negedge clk) begin
      if (log_clr) begin
         rd_n = 0; res_n = 0; thr_n = 0; done_n = 0; done_c = 0; rd_c0 = 0;
         res_c0 = 0; res_cl = 0; busy_gap = 0; pix_err = 0; res_ones = 0; one_addr = -1;
      end else begin
         if (img_rd === 1'b1) begin
            if (rd_n == 0) rd_c0 = ncyc;
            if (rd_n < NPIX) rd_log[rd_n] = int'(img_addr);
            rd_n++;
         end
         ep = prev_rd ? mem[prev_addr] : 8'd0;
         if (ate_pix !== ep) pix_err++;
         if (res_wr === 1'b1) begin
            if (res_n == 0) res_c0 = ncyc;
            res_cl = ncyc;
            if (res_n < NPIX) begin
               res_log[res_n]  = int'(res_addr);
               rbin_log[res_n] = res_bin;
            end
            if (res_bin === 1'b1) begin
               res_ones++;
               one_addr = int'(res_addr);
            end
            res_n++;
         end
         if (thr_wr === 1'b1) begin
            if (thr_n < 64) begin
               thr_a_log[thr_n] = int'(thr_addr);
               thr_v_log[thr_n] = int'(thr_val);
            end
            thr_n++;
         end
         if (mon && ncyc > run_s && done_n == 0 && done !== 1'b1 && busy !== 1'b1) busy_gap++;
         if (done === 1'b1) begin
            done_n++;
            done_c = ncyc;
            if (busy !== 1'b0) busy_gap++;
         end
      end
      prev_rd   = (img_rd === 1'b1);
      prev_addr = img_addr;
   end

   int rd_n2, thr_n2, done_n2, done_c2, last_rd2, last_thr2;
   always @(negedge clk) begin
      if (log_clr) begin
         rd_n2 = 0; thr_n2 = 0; done_n2 = 0; done_c2 = 0; last_rd2 = -1; last_thr2 = -1;
      end else begin
         if (img_rd2 === 1'b1) begin rd_n2++; last_rd2 = int'(img_addr2); end
         if (thr_wr2 === 1'b1) begin thr_n2++; last_thr2 = int'(thr_addr2); end
         if (done2 === 1'b1) begin done_n2++; done_c2 = ncyc; end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_addr(input int k, input int w);
      int b, nbx, p;
      nbx = w / 8;
      b   = k / 64;
      p   = k % 64;
      return ((b / nbx) * 8 + p / 8) * w + (b % nbx) * 8 + p % 8;
   endfunction

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic fill(input int mode);
      for (int i = 0; i < 4096; i++) begin
         logic [31:0] a;
         a = i;
         case (mode)
            0:       mem[i] = a[7:0];
            1:       mem[i] = 8'd100;
            default: mem[i] = (i == 53) ? 8'd200 : 8'd10;
         endcase
      end
   endtask

   task automatic clear_logs();
      step(1);
      log_clr = 1'b1;
      step(1);
      log_clr = 1'b0;
   endtask

   task automatic run_frame(output int s);
      clear_logs();
      s     = ncyc;
      run_s = s;
      mon   = 1'b1;
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic pulse_start_at(input int c);
      while (ncyc < c) step(1);
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int limit);
      int k;
      k = 0;
      while (done_n == 0 && k < limit) begin
         step(1);
         k++;
      end
      chk({tag, "_done_seen"}, (done_n > 0), 1);
      step(20);
      mon = 1'b0;
   endtask

   task automatic check_frame(input string tag, input int s);
      int ord_e, res_e, bin_e, ta_e, tv_e;
      ord_e = 0; res_e = 0; bin_e = 0; ta_e = 0; tv_e = 0;
      for (int i = 0; i < NPIX; i++) begin
         if (rd_log[i] != ref_addr(i, W)) ord_e++;
         if (res_log[i] != ref_addr(i, W)) res_e++;
         if (rbin_log[i] !== (mem[ref_addr(i, W)] >= lvl)) bin_e++;
      end
      for (int b = 0; b < NBLK; b++) begin
         if (thr_a_log[b] != b) ta_e++;
         if (thr_v_log[b] != int'(mem[ref_addr(b * 64, W)])) tv_e++;
      end
      chk({tag, "_done_latency"}, done_c - s, NPIX + LAT + 2);
      chk({tag, "_done_count"}, done_n, 1);
      chk({tag, "_rd_count"}, rd_n, NPIX);
      chk({tag, "_first_rd_cycle"}, rd_c0 - s, 1);
      chk({tag, "_rd_order_errs"}, ord_e, 0);
      chk({tag, "_ate_pix_errs"}, pix_err, 0);
      chk({tag, "_res_count"}, res_n, NPIX);
      chk({tag, "_res_start_offset"}, res_c0 - rd_c0, LAT + 1);
      chk({tag, "_res_window_span"}, res_cl - res_c0, NPIX - 1);
      chk({tag, "_res_addr_errs"}, res_e, 0);
      chk({tag, "_res_bin_errs"}, bin_e, 0);
      chk({tag, "_thr_count"}, thr_n, NBLK);
      chk({tag, "_thr_addr_errs"}, ta_e, 0);
      chk({tag, "_thr_val_errs"}, tv_e, 0);
      chk({tag, "_busy_gaps"}, busy_gap, 0);
   endtask

   initial begin
      int s;
      int k;
      int e10;
      int exp10 [10];
      exp10 = '{0, 1, 2, 3, 4, 5, 6, 7, 48, 49};

      fill(0);
      step(3);
      chk("reset_outputs", {busy, done, img_rd, img_addr, ate_pix, res_wr, res_addr,
                            res_bin, thr_wr, thr_addr, thr_val}, 64'd0);
      chk("reset_ate_type_48", ate_type, 1'b0);
      reset = 1'b0;
      step(2);
      chk("idle_no_busy", busy, 1'b0);

      // Ramp image.
      lvl = 8'd128;
      run_frame(s);
      wait_done("ramp", NPIX + 200);
      check_frame("ramp", s);
      e10 = 0;
      for (int i = 0; i < 10; i++) if (rd_log[i] != exp10[i]) e10++;
      chk("ramp_first_ten_addrs", e10, 0);
      chk("ramp_block1_first_addr", rd_log[64], 8);
      chk("ramp_last_addr", rd_log[NPIX-1], 1535);
      chk("ramp_thr_val_blk6", thr_v_log[6], 128);
      chk("ramp_bin_ones", res_ones, 768);

      // Constant image.
      fill(1);
      lvl = 8'd100;
      run_frame(s);
      wait_done("const", NPIX + 200);
      check_frame("const", s);
      chk("const_thr_val_last", thr_v_log[23], 100);
      chk("const_thr_addr_last", thr_a_log[23], 23);
      chk("const_bin_ones", res_ones, NPIX);

      // Single bright pixel at address 53.
      fill(2);
      lvl = 8'd128;
      run_frame(s);
      wait_done("spike", NPIX + 200);
      check_frame("spike", s);
      chk("spike_bin_ones", res_ones, 1);
      chk("spike_bin_addr", one_addr, 53);

      // Start pulses inside FEED and DRAIN must be ignored.
      fill(0);
      run_frame(s);
      pulse_start_at(s + 100);
      pulse_start_at(s + NPIX + 34);
      wait_done("restart", NPIX + 200);
      check_frame("restart", s);

      // Reset in the middle of the feed.
      run_frame(s);
      k = 0;
      while (rd_n < 700 && k < NPIX) begin
         step(1);
         k++;
      end
      chk("midreset_reached_700", rd_n, 700);
      mon   = 1'b0;
      reset = 1'b1;
      #1;
      chk("midreset_outputs_now", {busy, done, img_rd, img_addr, ate_pix, res_wr, res_addr,
                                   res_bin, thr_wr, thr_addr, thr_val}, 64'd0);
      step(1);
      chk("midreset_outputs_next", {busy, done, img_rd, img_addr, ate_pix, res_wr, res_addr,
                                    res_bin, thr_wr, thr_addr, thr_val}, 64'd0);
      reset = 1'b0;
      step(5);
      chk("midreset_no_done", done_n, 0);
      chk("midreset_idle", {busy, img_rd}, 2'b00);
      run_frame(s);
      wait_done("rerun", NPIX + 200);
      check_frame("rerun", s);

      // Wide geometry on the second instance.
      chk("wide_ate_type", ate_type2, 1'b1);
      clear_logs();
      s      = ncyc;
      start2 = 1'b1;
      step(1);
      start2 = 1'b0;
      k = 0;
      while (done_n2 == 0 && k < NPIX2 + 200) begin
         step(1);
         k++;
      end
      step(5);
      chk("wide_done_latency", done_c2 - s, NPIX2 + LAT + 2);
      chk("wide_rd_count", rd_n2, NPIX2);
      chk("wide_last_img_addr", last_rd2, 8447);
      chk("wide_thr_count", thr_n2, 132);
      chk("wide_last_thr_addr", last_thr2, 131);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
